uart_core: RTL and testbench

UART_CORE -- requirements
Module: uart_core

---
 rtl/uart_core.sv | 251 +++++++++++++++++++++++++
 tb/tb_uart_core.sv | 341 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_core.sv
`default_nettype none
// ============================================================================
// Module      : uart_core
// Description : Full-duplex UART with TX/RX FIFOs and sticky error flags.
//               Optional parity is enabled by defining UART_PARITY_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module uart_core #(
    parameter int CLK_FREQ   = 50000000,
    parameter int BAUD_RATE  = 9600,
    parameter int DATA_BITS  = 8,
    parameter int FIFO_DEPTH = 16,
    parameter int PARITY_ODD = 0
) (
    input  logic                          clk,
    input  logic                          reset_n,
    input  logic                          i_tx_valid,
    input  logic [DATA_BITS-1:0]          i_tx_data,
    output logic                          o_tx_ready,
    output logic                          o_tx,
    input  logic                          i_rx,
    output logic                          o_rx_valid,
    output logic [DATA_BITS-1:0]          o_rx_data,
    input  logic                          i_rx_ready,
    output logic                          o_tx_busy,
    output logic [$clog2(FIFO_DEPTH):0]   o_tx_level,
    output logic [$clog2(FIFO_DEPTH):0]   o_rx_level,
    output logic                          o_frame_err,
    output logic                          o_overflow,
    output logic                          o_parity_err,
    input  logic                          i_clear_err
);

    localparam int c_cpb = CLK_FREQ / BAUD_RATE;
    localparam int c_cw  = $clog2(c_cpb);
    localparam int c_aw  = $clog2(FIFO_DEPTH);
    localparam int c_lw  = c_aw + 1;
    localparam int c_bw  = $clog2(DATA_BITS);
    localparam logic [c_cw-1:0] c_cnt_last = c_cw'(c_cpb - 1);
    localparam logic [c_cw-1:0] c_cnt_half = c_cw'(c_cpb / 2 - 1);
    localparam logic [c_bw-1:0] c_bit_last = c_bw'(DATA_BITS - 1);
    localparam logic [c_lw-1:0] c_full     = c_lw'(FIFO_DEPTH);
    localparam logic            c_par_odd  = (PARITY_ODD != 0);
`ifdef UART_PARITY_EN
    localparam logic            c_par_en   = 1'b1;
`else
    localparam logic            c_par_en   = 1'b0;
`endif

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_START  = 3'd1,
        S_DATA   = 3'd2,
        S_PARITY = 3'd3,
        S_STOP   = 3'd4
    } state_t;

    // ---------------------------------------------------------------- TX
    logic [DATA_BITS-1:0] r_tx_mem [FIFO_DEPTH];
    logic [c_aw-1:0]      r_tx_wp, r_tx_rp;
    logic [c_lw-1:0]      r_tx_cnt;
    state_t               r_tx_state;
    logic [c_cw-1:0]      r_tx_tick;
    logic [c_bw-1:0]      r_tx_bitc;
    logic [DATA_BITS-1:0] r_tx_shift;
    logic                 r_tx_par;
    logic                 r_tx;
    logic                 w_tx_push, w_tx_load;
    logic [DATA_BITS-1:0] w_tx_head;

    assign o_tx_ready = (r_tx_cnt != c_full);
    assign w_tx_push  = i_tx_valid && o_tx_ready;
    assign w_tx_head  = r_tx_mem[r_tx_rp];
    // A new frame may start from IDLE or straight out of the last STOP cycle.
    assign w_tx_load  = (r_tx_cnt != '0) &&
                        ((r_tx_state == S_IDLE) ||
                         (r_tx_state == S_STOP && r_tx_tick == c_cnt_last));
    assign o_tx       = r_tx;
    assign o_tx_busy  = (r_tx_state != S_IDLE) || (r_tx_cnt != '0);
    assign o_tx_level = r_tx_cnt;

    always_ff @(posedge clk) begin
        if (w_tx_push) r_tx_mem[r_tx_wp] <= i_tx_data;
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_tx_wp  <= '0;
            r_tx_rp  <= '0;
            r_tx_cnt <= '0;
        end else begin
            if (w_tx_push) r_tx_wp <= r_tx_wp + 1'b1;
            if (w_tx_load) r_tx_rp <= r_tx_rp + 1'b1;
            if (w_tx_push && !w_tx_load)      r_tx_cnt <= r_tx_cnt + 1'b1;
            else if (!w_tx_push && w_tx_load) r_tx_cnt <= r_tx_cnt - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_tx_state <= S_IDLE;
            r_tx_tick  <= '0;
            r_tx_bitc  <= '0;
            r_tx_shift <= '0;
            r_tx_par   <= 1'b0;
            r_tx       <= 1'b1;
        end else begin
            r_tx_tick <= r_tx_tick + 1'b1;
            case (r_tx_state)
                S_IDLE: r_tx_tick <= '0;
                S_START: if (r_tx_tick == c_cnt_last) begin
                    r_tx_tick  <= '0;
                    r_tx_bitc  <= '0;
                    r_tx       <= r_tx_shift[0];
                    r_tx_shift <= r_tx_shift >> 1;
                    r_tx_state <= S_DATA;
                end
                S_DATA: if (r_tx_tick == c_cnt_last) begin
                    r_tx_tick <= '0;
                    if (r_tx_bitc == c_bit_last) begin
                        r_tx       <= c_par_en ? r_tx_par : 1'b1;
                        r_tx_state <= c_par_en ? S_PARITY : S_STOP;
                    end else begin
                        r_tx_bitc  <= r_tx_bitc + 1'b1;
                        r_tx       <= r_tx_shift[0];
                        r_tx_shift <= r_tx_shift >> 1;
                    end
                end
                S_PARITY: if (r_tx_tick == c_cnt_last) begin
                    r_tx_tick  <= '0;
                    r_tx       <= 1'b1;
                    r_tx_state <= S_STOP;
                end
                S_STOP: if (r_tx_tick == c_cnt_last) begin
                    r_tx_tick  <= '0;
                    r_tx_state <= S_IDLE;
                end
                default: r_tx_state <= S_IDLE;
            endcase
            // Overrides the STOP->IDLE move for back-to-back frames.
            if (w_tx_load) begin
                r_tx_shift <= w_tx_head;
                r_tx_par   <= (^w_tx_head) ^ c_par_odd;
                r_tx       <= 1'b0;
                r_tx_tick  <= '0;
                r_tx_state <= S_START;
            end
        end
    end

    // ---------------------------------------------------------------- RX
    logic [DATA_BITS-1:0] r_rx_mem [FIFO_DEPTH];
    logic [c_aw-1:0]      r_rx_wp, r_rx_rp;
    logic [c_lw-1:0]      r_rx_cnt;
    logic                 r_rx_meta, r_rx_sync;
    state_t               r_rx_state;
    logic [c_cw-1:0]      r_rx_tick;
    logic [c_bw-1:0]      r_rx_bitc;
    logic [DATA_BITS-1:0] r_rx_shift;
    logic                 r_rx_par;
    logic                 r_frame_err, r_overflow, r_parity_err;
    logic                 w_rx_stop, w_par_ok, w_rx_pop, w_rx_room, w_rx_push;

    assign w_rx_stop    = (r_rx_state == S_STOP) && (r_rx_tick == c_cnt_last);
    assign w_par_ok     = !c_par_en || (((^r_rx_shift) ^ c_par_odd) == r_rx_par);
    assign w_rx_pop     = i_rx_ready && (r_rx_cnt != '0);
    assign w_rx_room    = (r_rx_cnt != c_full) || w_rx_pop;
    assign w_rx_push    = w_rx_stop && r_rx_sync && w_par_ok && w_rx_room;
    assign o_rx_valid   = (r_rx_cnt != '0);
    assign o_rx_data    = o_rx_valid ? r_rx_mem[r_rx_rp] : '0;
    assign o_rx_level   = r_rx_cnt;
    assign o_frame_err  = r_frame_err;
    assign o_overflow   = r_overflow;
    assign o_parity_err = c_par_en ? r_parity_err : 1'b0;

    always_ff @(posedge clk) begin
        if (w_rx_push) r_rx_mem[r_rx_wp] <= r_rx_shift;
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_rx_wp   <= '0;
            r_rx_rp   <= '0;
            r_rx_cnt  <= '0;
            r_rx_meta <= 1'b1;
            r_rx_sync <= 1'b1;
        end else begin
            r_rx_meta <= i_rx;
            r_rx_sync <= r_rx_meta;
            if (w_rx_push) r_rx_wp <= r_rx_wp + 1'b1;
            if (w_rx_pop)  r_rx_rp <= r_rx_rp + 1'b1;
            if (w_rx_push && !w_rx_pop)      r_rx_cnt <= r_rx_cnt + 1'b1;
            else if (!w_rx_push && w_rx_pop) r_rx_cnt <= r_rx_cnt - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_rx_state   <= S_IDLE;
            r_rx_tick    <= '0;
            r_rx_bitc    <= '0;
            r_rx_shift   <= '0;
            r_rx_par     <= 1'b0;
            r_frame_err  <= 1'b0;
            r_overflow   <= 1'b0;
            r_parity_err <= 1'b0;
        end else begin
            r_rx_tick <= r_rx_tick + 1'b1;
            // Clear first so an error event in the same cycle wins.
            if (i_clear_err) begin
                r_frame_err  <= 1'b0;
                r_overflow   <= 1'b0;
                r_parity_err <= 1'b0;
            end
            case (r_rx_state)
                S_IDLE: begin
                    r_rx_tick <= '0;
                    if (!r_rx_sync) r_rx_state <= S_START;
                end
                S_START: if (r_rx_tick == c_cnt_half) begin
                    r_rx_tick  <= '0;
                    r_rx_bitc  <= '0;
                    r_rx_state <= r_rx_sync ? S_IDLE : S_DATA;
                end
                S_DATA: if (r_rx_tick == c_cnt_last) begin
                    r_rx_tick  <= '0;
                    r_rx_shift <= {r_rx_sync, r_rx_shift[DATA_BITS-1:1]};
                    if (r_rx_bitc == c_bit_last)
                        r_rx_state <= c_par_en ? S_PARITY : S_STOP;
                    else
                        r_rx_bitc <= r_rx_bitc + 1'b1;
                end
                S_PARITY: if (r_rx_tick == c_cnt_last) begin
                    r_rx_tick  <= '0;
                    r_rx_par   <= r_rx_sync;
                    r_rx_state <= S_STOP;
                end
                S_STOP: if (r_rx_tick == c_cnt_last) begin
                    r_rx_tick  <= '0;
                    r_rx_state <= S_IDLE;
                    if (!r_rx_sync)      r_frame_err  <= 1'b1;
                    else if (!w_par_ok)  r_parity_err <= 1'b1;
                    else if (!w_rx_room) r_overflow   <= 1'b1;
                end
                default: r_rx_state <= S_IDLE;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_uart_core.sv
`default_nettype none
// ============================================================================
// Module      : tb_uart_core
// Description : Self-checking bench for uart_core (10 cycles/bit, depth 4).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_uart_core;

    localparam int CPB = 10;
    localparam int PARITY_ODD = 0;
`ifdef UART_PARITY_EN
    localparam int PAR_EN = 1;
`else
    localparam int PAR_EN = 0;
`endif
    localparam int NB = 10 + PAR_EN;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic       tx_valid = 1'b0;
    logic [7:0] tx_data = 8'h00;
    logic       tx_ready, tx_line, rx_valid, tx_busy;
    logic [7:0] rx_data;
    logic       rx_ready = 1'b0;
    logic [2:0] tx_level, rx_level;
    logic       frame_err, overflow, parity_err;
    logic       clear_err = 1'b0;
    logic       loop_en = 1'b0;
    logic       rx_drive = 1'b1;
    logic       rx_line;

    int n_vec = 0;
    int n_err = 0;

    assign rx_line = loop_en ? tx_line : rx_drive;

    uart_core #(
        .CLK_FREQ(1000000), .BAUD_RATE(100000), .DATA_BITS(8),
        .FIFO_DEPTH(4), .PARITY_ODD(PARITY_ODD)
    ) dut (
        .clk(clk), .reset_n(reset_n),
        .i_tx_valid(tx_valid), .i_tx_data(tx_data), .o_tx_ready(tx_ready),
        .o_tx(tx_line), .i_rx(rx_line),
        .o_rx_valid(rx_valid), .o_rx_data(rx_data), .i_rx_ready(rx_ready),
        .o_tx_busy(tx_busy), .o_tx_level(tx_level), .o_rx_level(rx_level),
        .o_frame_err(frame_err), .o_overflow(overflow), .o_parity_err(parity_err),
        .i_clear_err(clear_err)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Serial frame as a list of line levels: start, data LSB first, parity, stop.
    function automatic logic exp_bit(input logic [7:0] d, input int i);
        if (i == 0) return 1'b0;
        if (i <= 8) return d[i-1];
        if (PAR_EN != 0 && i == 9) return (^d) ^ (PARITY_ODD != 0);
        return 1'b1;
    endfunction

    function automatic logic [20:0] status();
        return {tx_line, tx_ready, rx_valid, tx_busy, frame_err, overflow,
                parity_err, tx_level, rx_level, rx_data};
    endfunction

    task automatic send_rx(input logic [7:0] d, input logic stop_bit, input logic par_bit);
        logic [10:0] bits;
        bits = '1;
        bits[0] = 1'b0;
        bits[8:1] = d;
        if (PAR_EN != 0) bits[9] = par_bit;
        bits[NB-1] = stop_bit;
        for (int i = 0; i < NB; i++)
            for (int c = 0; c < CPB; c++) begin
                rx_drive = bits[i];
                tick();
            end
        rx_drive = 1'b1;
    endtask

    task automatic wait_tx_idle();
        for (int k = 0; k < 2000 && tx_busy; k++) tick();
        for (int k = 0; k < 30; k++) tick();
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        tick(); tick();
        n_vec++;
        if (status() !== {2'b11, 19'd0}) begin
            n_err++;
            $display("FAIL reset_state: got %h want %h", status(), {2'b11, 19'd0});
        end
        reset_n = 1'b1;
        tick();
    endtask

    task automatic check_tx_frame(input logic [7:0] d, input string name);
        int k;
        tx_valid = 1'b1; tx_data = d;
        tick();
        tx_valid = 1'b0;
        for (k = 0; k < 6 && tx_line !== 1'b0; k++) tick();
        n_vec++;
        if (tx_line !== 1'b0) begin
            n_err++;
            $display("FAIL %s_start: got %b want 0", name, tx_line);
        end
        for (int t = 0; t < NB * CPB; t++) begin
            n_vec++;
            if (tx_line !== exp_bit(d, t / CPB)) begin
                n_err++;
                $display("FAIL %s_bit%0d_cyc%0d: got %b want %b", name, t / CPB, t % CPB,
                         tx_line, exp_bit(d, t / CPB));
            end
            tick();
        end
        n_vec++;
        if ({tx_busy, tx_line} !== 2'b01) begin
            n_err++;
            $display("FAIL %s_idle_after: busy,tx got %b want 01", name, {tx_busy, tx_line});
        end
    endtask

    task automatic test_tx_frame();
        check_tx_frame(8'hA5, "tx_a5");
        for (int r = 0; r < 2; r++) check_tx_frame(8'($urandom), "tx_rand");
    endtask

    task automatic test_back_to_back();
        logic [7:0] vals [5];
        int idx = 0, t = 0;
        bit started = 0, acc;
        for (int i = 0; i < 5; i++) vals[i] = 8'(i + 1);
        tx_valid = 1'b1; tx_data = vals[0];
        for (int it = 0; it < 700 && t < 5 * NB * CPB; it++) begin
            if (!started && tx_line === 1'b0) started = 1;
            if (started) begin
                n_vec++;
                if (tx_line !== exp_bit(vals[t / (NB * CPB)], (t % (NB * CPB)) / CPB)) begin
                    n_err++;
                    $display("FAIL b2b_frame%0d_t%0d: got %b want %b", t / (NB * CPB), t,
                             tx_line, exp_bit(vals[t / (NB * CPB)], (t % (NB * CPB)) / CPB));
                end
                t++;
            end
            acc = tx_valid && tx_ready;
            tick();
            if (acc) begin
                idx++;
                if (idx < 5) tx_data = vals[idx];
                else begin
                    tx_valid = 1'b0;
                    n_vec++;
                    if ({tx_ready, tx_level} !== {1'b0, 3'd4}) begin
                        n_err++;
                        $display("FAIL b2b_full: ready,level got %b want 0100", {tx_ready, tx_level});
                    end
                end
            end
        end
        tx_valid = 1'b0;
        n_vec++;
        if (t != 5 * NB * CPB) begin
            n_err++;
            $display("FAIL b2b_timeout: checked %0d want %0d cycles", t, 5 * NB * CPB);
        end
        wait_tx_idle();
    endtask

    task automatic test_loopback();
        loop_en = 1'b1; rx_ready = 1'b0;
        tx_valid = 1'b1; tx_data = 8'h3C;
        tick();
        tx_valid = 1'b0;
        for (int k = 0; k < 200 && !rx_valid; k++) tick();
        n_vec++;
        if ({rx_valid, rx_data, rx_level} !== {1'b1, 8'h3C, 3'd1}) begin
            n_err++;
            $display("FAIL loop_rx: valid,data,level got %b want %b",
                     {rx_valid, rx_data, rx_level}, {1'b1, 8'h3C, 3'd1});
        end
        rx_ready = 1'b1; tick(); rx_ready = 1'b0;
        n_vec++;
        if ({rx_valid, rx_level} !== 4'b0000) begin
            n_err++;
            $display("FAIL loop_pop: valid,level got %b want 0000", {rx_valid, rx_level});
        end
        wait_tx_idle();
    endtask

    task automatic test_random_loopback();
        logic [7:0] q [$];
        int sent = 0, rcv = 0, n = 8;
        bit acc;
        for (int i = 0; i < n; i++) q.push_back(8'($urandom));
        loop_en = 1'b1;
        tx_valid = 1'b1; tx_data = q[0];
        for (int it = 0; it < 3000 && rcv < n; it++) begin
            rx_ready = 1'($urandom_range(0, 1));
            if (rx_valid && rx_ready) begin
                n_vec++;
                if (rx_data !== q[rcv]) begin
                    n_err++;
                    $display("FAIL rand_loop_byte%0d: got %h want %h", rcv, rx_data, q[rcv]);
                end
                rcv++;
            end
            acc = tx_valid && tx_ready;
            tick();
            if (acc) begin
                sent++;
                if (sent < n) tx_data = q[sent];
                else tx_valid = 1'b0;
            end
        end
        tx_valid = 1'b0; rx_ready = 1'b0;
        n_vec++;
        if ({rcv[7:0], frame_err, overflow} !== {8'(n), 2'b00}) begin
            n_err++;
            $display("FAIL rand_loop_done: rcv=%0d ferr=%b ovf=%b want %0d 0 0",
                     rcv, frame_err, overflow, n);
        end
        wait_tx_idle();
        loop_en = 1'b0;
    endtask

    task automatic test_glitch_frame_err();
        loop_en = 1'b0; rx_drive = 1'b1;
        for (int k = 0; k < 4; k++) begin rx_drive = 1'b0; tick(); end
        rx_drive = 1'b1;
        for (int k = 0; k < 30; k++) tick();
        n_vec++;
        if ({rx_level, frame_err, overflow, parity_err} !== 6'd0) begin
            n_err++;
            $display("FAIL glitch: level,ferr,ovf,perr got %b want 000000",
                     {rx_level, frame_err, overflow, parity_err});
        end
        send_rx(8'h55, 1'b0, 1'b0);
        for (int k = 0; k < 20; k++) tick();
        n_vec++;
        if ({frame_err, rx_level} !== {1'b1, 3'd0}) begin
            n_err++;
            $display("FAIL frame_err_set: ferr,level got %b want 1000", {frame_err, rx_level});
        end
        clear_err = 1'b1; tick(); clear_err = 1'b0;
        n_vec++;
        if (frame_err !== 1'b0) begin
            n_err++;
            $display("FAIL frame_err_clear: got %b want 0", frame_err);
        end
    endtask

    task automatic test_overflow();
        logic [7:0] b [5];
        rx_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            b[i] = 8'($urandom);
            send_rx(b[i], 1'b1, (^b[i]) ^ (PARITY_ODD != 0));
        end
        for (int k = 0; k < 10; k++) tick();
        n_vec++;
        if ({rx_level, overflow, rx_data} !== {3'd4, 1'b1, b[0]}) begin
            n_err++;
            $display("FAIL overflow: level,ovf,head got %0d %b %h want 4 1 %h",
                     rx_level, overflow, rx_data, b[0]);
        end
        for (int i = 0; i < 4; i++) begin
            n_vec++;
            if (rx_data !== b[i]) begin
                n_err++;
                $display("FAIL overflow_drain%0d: got %h want %h", i, rx_data, b[i]);
            end
            rx_ready = 1'b1; tick(); rx_ready = 1'b0;
        end
        clear_err = 1'b1; tick(); clear_err = 1'b0;
        n_vec++;
        if ({overflow, rx_level} !== 4'b0000) begin
            n_err++;
            $display("FAIL overflow_clear: ovf,level got %b want 0000", {overflow, rx_level});
        end
    endtask

`ifdef UART_PARITY_EN
    task automatic test_parity();
        send_rx(8'h07, 1'b1, 1'b0);
        for (int k = 0; k < 10; k++) tick();
        n_vec++;
        if ({parity_err, rx_level} !== {1'b1, 3'd0}) begin
            n_err++;
            $display("FAIL parity_err: perr,level got %b want 1000", {parity_err, rx_level});
        end
    endtask
`endif

    task automatic test_reset_midframe();
        loop_en = 1'b1;
        tx_valid = 1'b1; tx_data = 8'h00;
        tick();
        tx_valid = 1'b0;
        for (int k = 0; k < 35; k++) tick();
        reset_n = 1'b0;
        tick();
        n_vec++;
        if (status() !== {2'b11, 19'd0}) begin
            n_err++;
            $display("FAIL reset_midframe: got %h want %h", status(), {2'b11, 19'd0});
        end
        reset_n = 1'b1;
        for (int k = 0; k < 150; k++) tick();
        n_vec++;
        if ({tx_line, tx_busy, rx_level, frame_err} !== {1'b1, 1'b0, 3'd0, 1'b0}) begin
            n_err++;
            $display("FAIL reset_abort: tx,busy,rxlvl,ferr got %b want 100000",
                     {tx_line, tx_busy, rx_level, frame_err});
        end
        loop_en = 1'b0;
    endtask

    initial begin
        test_reset();
        test_tx_frame();
        test_back_to_back();
        test_loopback();
        test_random_loopback();
        test_glitch_frame_err();
        test_overflow();
`ifdef UART_PARITY_EN
        test_parity();
`endif
        test_reset_midframe();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
